// File: rtl/ev3a_gen_ctrl.sv
// rtl/ev3a_gen_ctrl.sv - EV3a generation sequencer: load, evaluate, crossover, mutate, elitist best tracking.
// Optional cycle watchdog on handshake waits is compiled in with WATCHDOG_EN.
module ev3a_gen_ctrl #(
  parameter int INT8_LENGTH    = 8,
  parameter int IND_FIT_LENGTH = 10,
  parameter int MAX_POP        = 64,
  parameter int ADDR_W         = 6,
  parameter int WDOG_CYCLES    = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [INT8_LENGTH-1:0]    Num_generations,
  input  logic [INT8_LENGTH-1:0]    Pop_size,
  input  logic [INT8_LENGTH-1:0]    crossoverFraction,
  output logic                      pop_wr_en,
  output logic [ADDR_W-1:0]         pop_wr_addr,
  output logic                      eval_req,
  output logic [ADDR_W-1:0]         eval_idx,
  input  logic                      eval_ack,
  input  logic [IND_FIT_LENGTH-1:0] fit_in,
  output logic                      xo_start,
  output logic [INT8_LENGTH-1:0]    xo_count,
  input  logic                      xo_done,
  output logic                      mut_start,
  input  logic                      mut_done,
  output logic [INT8_LENGTH-1:0]    gen_cnt,
  output logic [IND_FIT_LENGTH-1:0] Min_fit_out,
  output logic [ADDR_W-1:0]         Best_idx,
  output logic                      done,
  output logic                      err
);
  localparam int PW = 2 * INT8_LENGTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_XOVER, S_MUTATE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [INT8_LENGTH-1:0]    num_gen_q, num_gen_d, pop_q, pop_d, xfrac_q, xfrac_d;
  logic [INT8_LENGTH-1:0]    wr_cnt_q, wr_cnt_d, gen_cnt_q, gen_cnt_d, xo_count_q, xo_count_d;
  logic [ADDR_W-1:0]         eval_idx_q, eval_idx_d, best_idx_q, best_idx_d, best_out_q, best_out_d;
  logic [IND_FIT_LENGTH-1:0] best_fit_q, best_fit_d, min_fit_q, min_fit_d;
  logic                      eval_req_q, eval_req_d, xo_start_q, xo_start_d, mut_start_q, mut_start_d;
  logic                      done_q, done_d, err_q, err_d;
  logic [INT8_LENGTH-1:0]    pop_clamped;
  logic [PW-1:0]             xo_prod;
  logic                      eval_last, ack_taken, go_done, wd_expire;

  assign xo_prod   = PW'(pop_q) * PW'(xfrac_q);
  assign eval_last = (INT8_LENGTH'(eval_idx_q) == pop_q - 1'b1);
  assign ack_taken = (state_q == S_EVAL) && eval_req_q && eval_ack;

  always_comb begin
    pop_clamped = Pop_size;
    if (Pop_size == '0)
      pop_clamped = INT8_LENGTH'(1);
    else if (Pop_size > INT8_LENGTH'(MAX_POP))
      pop_clamped = INT8_LENGTH'(MAX_POP);
  end

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  assign wd_expire = (wdog_q == WD_W'(WDOG_CYCLES - 1));

  // Restarts on every state change and on each accepted fitness result.
  always_comb begin
    wdog_d = '0;
    if ((state_d == state_q) && !ack_taken &&
        (state_q == S_EVAL || state_q == S_XOVER || state_q == S_MUTATE))
      wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Write strobe follows the beat in the same cycle; beats past the population are dropped.
  always_comb begin
    pop_wr_en   = 1'b0;
    pop_wr_addr = '0;
    if (rst_n && in_valid) begin
      if (state_q == S_IDLE) begin
        pop_wr_en = 1'b1;
      end else if (state_q == S_LOAD) begin
        pop_wr_en   = (wr_cnt_q < pop_q);
        pop_wr_addr = wr_cnt_q[ADDR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    num_gen_d   = num_gen_q;
    pop_d       = pop_q;
    xfrac_d     = xfrac_q;
    wr_cnt_d    = wr_cnt_q;
    gen_cnt_d   = gen_cnt_q;
    xo_count_d  = xo_count_q;
    eval_idx_d  = eval_idx_q;
    best_idx_d  = best_idx_q;
    best_fit_d  = best_fit_q;
    eval_req_d  = eval_req_q;
    xo_start_d  = 1'b0;
    mut_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    min_fit_d   = '0;
    best_out_d  = '0;
    go_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          num_gen_d  = Num_generations;
          pop_d      = pop_clamped;
          xfrac_d    = crossoverFraction;
          best_fit_d = '1;
          best_idx_d = '0;
          gen_cnt_d  = '0;
          wr_cnt_d   = INT8_LENGTH'(1);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
        end else begin
          eval_idx_d = '0;
          eval_req_d = 1'b0;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!eval_req_q) begin
          eval_req_d = 1'b1;
        end else if (eval_ack) begin
          eval_req_d = 1'b0;
          if (fit_in < best_fit_q) begin
            best_fit_d = fit_in;
            best_idx_d = eval_idx_q;
          end
          if (!eval_last) begin
            eval_idx_d = eval_idx_q + 1'b1;
          end else if (gen_cnt_q == num_gen_q) begin
            go_done = 1'b1;
          end else begin
            xo_start_d = 1'b1;
            xo_count_d = xo_prod[PW-1:INT8_LENGTH];
            state_d    = S_XOVER;
          end
        end else if (wd_expire) begin
          go_done = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_XOVER: begin
        if (xo_done) begin
          mut_start_d = 1'b1;
          state_d     = S_MUTATE;
        end else if (wd_expire) begin
          go_done = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_MUTATE: begin
        if (mut_done) begin
          if (gen_cnt_q != '1) gen_cnt_d = gen_cnt_q + 1'b1;
          eval_idx_d = '0;
          eval_req_d = 1'b0;
          state_d    = S_EVAL;
        end else if (wd_expire) begin
          go_done = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result is presented only on the done pulse, including a result updated this cycle.
    if (go_done) begin
      state_d    = S_DONE;
      eval_req_d = 1'b0;
      done_d     = 1'b1;
      min_fit_d  = best_fit_d;
      best_out_d = best_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_gen_q   <= '0;
      pop_q       <= '0;
      xfrac_q     <= '0;
      wr_cnt_q    <= '0;
      gen_cnt_q   <= '0;
      xo_count_q  <= '0;
      eval_idx_q  <= '0;
      best_idx_q  <= '0;
      best_fit_q  <= '1;
      eval_req_q  <= 1'b0;
      xo_start_q  <= 1'b0;
      mut_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      min_fit_q   <= '0;
      best_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_gen_q   <= num_gen_d;
      pop_q       <= pop_d;
      xfrac_q     <= xfrac_d;
      wr_cnt_q    <= wr_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
      xo_count_q  <= xo_count_d;
      eval_idx_q  <= eval_idx_d;
      best_idx_q  <= best_idx_d;
      best_fit_q  <= best_fit_d;
      eval_req_q  <= eval_req_d;
      xo_start_q  <= xo_start_d;
      mut_start_q <= mut_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      min_fit_q   <= min_fit_d;
      best_out_q  <= best_out_d;
    end
  end

  assign eval_req    = eval_req_q;
  assign eval_idx    = eval_idx_q;
  assign xo_start    = xo_start_q;
  assign xo_count    = xo_count_q;
  assign mut_start   = mut_start_q;
  assign gen_cnt     = gen_cnt_q;
  assign Min_fit_out = min_fit_q;
  assign Best_idx    = best_out_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ev3a_gen_ctrl.sv
// tb/tb_ev3a_gen_ctrl.sv - self-checking bench for ev3a_gen_ctrl: vector table, random runs, corner sequences.
module tb_ev3a_gen_ctrl;
  localparam int W = 8, F = 10, MP = 64, AW = 6, WD = 1023;

  logic          clk, rst_n, in_valid, eval_ack, xo_done, mut_done;
  logic [W-1:0]  Num_generations, Pop_size, crossoverFraction;
  logic          pop_wr_en, eval_req, xo_start, mut_start, done, err;
  logic [AW-1:0] pop_wr_addr, eval_idx, Best_idx;
  logic [F-1:0]  fit_in, Min_fit_out;
  logic [W-1:0]  xo_count, gen_cnt;

  ev3a_gen_ctrl #(.INT8_LENGTH(W), .IND_FIT_LENGTH(F), .MAX_POP(MP), .ADDR_W(AW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Num_generations(Num_generations),
    .Pop_size(Pop_size), .crossoverFraction(crossoverFraction), .pop_wr_en(pop_wr_en),
    .pop_wr_addr(pop_wr_addr), .eval_req(eval_req), .eval_idx(eval_idx), .eval_ack(eval_ack),
    .fit_in(fit_in), .xo_start(xo_start), .xo_count(xo_count), .xo_done(xo_done),
    .mut_start(mut_start), .mut_done(mut_done), .gen_cnt(gen_cnt), .Min_fit_out(Min_fit_out),
    .Best_idx(Best_idx), .done(done), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0, check_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tab[0:319];
  int n_wr, beat, addr_err, n_eval, idx_err, n_xo, n_mut, n_done, zero_err;
  int cap_gen, cap_fit, cap_idx, cap_err, cap_xocnt, xo_cyc, done_cyc;
  int pop_eff_m, fixed_lat, ev_wait, ev_lat, xo_pend, xo_lat, mut_pend, mut_lat;
  bit xo_hold, stray;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int new_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  task automatic clear_mon();
    n_wr = 0; beat = 0; addr_err = 0; n_eval = 0; idx_err = 0; n_xo = 0; n_mut = 0;
    n_done = 0; zero_err = 0; cap_gen = 0; cap_fit = 0; cap_idx = 0; cap_err = 0;
    cap_xocnt = 0; xo_cyc = 0; done_cyc = 0; ev_wait = 0; ev_lat = new_lat();
    xo_pend = 0; mut_pend = 0;
  endtask

  // Observes outputs and plays the fitness / crossover / mutation agents on the falling edge.
  initial begin
    eval_ack = 0; xo_done = 0; mut_done = 0; fit_in = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++; cap_gen = gen_cnt; cap_fit = Min_fit_out; cap_idx = Best_idx;
        cap_err = err; done_cyc = cyc;
      end else if (Min_fit_out != 0 || Best_idx != 0 || err != 0) zero_err++;
      if (xo_start) begin n_xo++; cap_xocnt = xo_count; xo_cyc = cyc; xo_pend = 1; xo_lat = new_lat(); end
      if (mut_start) begin n_mut++; mut_pend = 1; mut_lat = new_lat(); end
      if (in_valid) begin
        if (pop_wr_en) begin
          if (pop_wr_addr != AW'(beat)) addr_err++;
          n_wr++;
        end
        beat++;
      end
      eval_ack = 0; xo_done = 0; mut_done = 0;
      if (stray) begin
        eval_ack = 1; xo_done = 1; mut_done = 1;
      end else begin
        if (eval_req) begin
          if (ev_wait >= ev_lat) begin
            eval_ack = 1;
            fit_in = F'(tab[(n_mut % 5) * 64 + int'(eval_idx)]);
            if (int'(eval_idx) != n_eval % pop_eff_m) idx_err++;
            n_eval++; ev_wait = 0; ev_lat = new_lat();
          end else ev_wait++;
        end
        if (xo_pend != 0 && !xo_hold) begin
          if (xo_lat == 0) begin xo_done = 1; xo_pend = 0; end else xo_lat--;
        end
        if (mut_pend != 0) begin
          if (mut_lat == 0) begin mut_done = 1; mut_pend = 0; end else mut_lat--;
        end
      end
    end
  end

  function automatic int clamp_pop(input int ps);
    return (ps < 1) ? 1 : (ps > MP) ? MP : ps;
  endfunction

  // Elitist best: strictly smaller replaces, scanning generations then indices in order.
  task automatic model_best(input int pe, input int ng, output int bf, output int bi);
    bf = 1023; bi = 0;
    for (int g = 0; g <= ng; g++)
      for (int i = 0; i < pe; i++)
        if (tab[g * 64 + i] < bf) begin bf = tab[g * 64 + i]; bi = i; end
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < 320; i++) tab[i] = int'($urandom_range(lo, hi));
  endtask

  task automatic drive_cfg(input int ps, input int ng, input int xf, input int beats);
    for (int b = 0; b < beats; b++) begin
      in_valid = 1;
      if (b == 0) begin
        Pop_size = W'(ps); Num_generations = W'(ng); crossoverFraction = W'(xf);
      end else begin
        Pop_size = W'($urandom); Num_generations = W'($urandom); crossoverFraction = W'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic run_case(input string tag, input int ps, input int ng, input int xf, input int beats,
                          input int lat, input int e_wr, input int e_xo, input int e_ev, input int e_xon,
                          input int e_fit, input int e_idx);
    int t;
    fixed_lat = lat;
    clear_mon();
    pop_eff_m = clamp_pop(ps);
    drive_cfg(ps, ng, xf, beats);
    t = 0;
    while (n_done == 0 && t < 30000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".done_cnt"}, n_done, 1);
    check({tag, ".wr_cnt"}, n_wr, e_wr);
    check({tag, ".wr_addr_err"}, addr_err, 0);
    check({tag, ".evals"}, n_eval, e_ev);
    check({tag, ".eval_idx_err"}, idx_err, 0);
    check({tag, ".xo_starts"}, n_xo, e_xon);
    check({tag, ".mut_starts"}, n_mut, e_xon);
    check({tag, ".xo_count"}, cap_xocnt, e_xo);
    check({tag, ".gen_at_done"}, cap_gen, ng);
    check({tag, ".gen_hold"}, int'(gen_cnt), ng);
    check({tag, ".min_fit"}, cap_fit, e_fit);
    check({tag, ".best_idx"}, cap_idx, e_idx);
    check({tag, ".err"}, cap_err, 0);
    check({tag, ".zero_when_idle"}, zero_err, 0);
  endtask

  typedef struct {
    int pop_size, ngen, xfrac, beats, lat;
    int exp_wr, exp_xo, exp_evals, exp_xon;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bf, bi, ps, ng, xf, bt, pe, t;
    vecs[0] = '{40, 0, 128, 40,  1, 40,  0,  40, 0};
    vecs[1] = '{40, 2, 204, 40, -1, 40, 31, 120, 2};
    vecs[2] = '{40, 1, 255, 42,  0, 40, 39,  80, 1};
    vecs[3] = '{ 0, 1, 128,  3, -1,  1,  0,   2, 1};
    vecs[4] = '{100, 1, 100, 70, -1, 64, 25, 128, 1};
    vecs[5] = '{ 8, 3,   0,  4,  2,  4,  0,  32, 3};
    vecs[6] = '{64, 0, 255, 64, -1, 64,  0,  64, 0};

    rst_n = 0; in_valid = 0; Pop_size = 0; Num_generations = 0; crossoverFraction = 0;
    xo_hold = 0; stray = 0; fixed_lat = 0; pop_eff_m = 1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset.pop_wr_en", pop_wr_en, 0);
    check("reset.eval_req", eval_req, 0);
    check("reset.done", done, 0);
    check("reset.gen_cnt", gen_cnt, 0);
    check("reset.min_fit", Min_fit_out, 0);
    check("reset.xo_start", xo_start, 0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      fill_rand(40, 60);
      model_best(clamp_pop(vecs[v].pop_size), vecs[v].ngen, bf, bi);
      run_case($sformatf("vec%0d", v), vecs[v].pop_size, vecs[v].ngen, vecs[v].xfrac, vecs[v].beats,
               vecs[v].lat, vecs[v].exp_wr, vecs[v].exp_xo, vecs[v].exp_evals, vecs[v].exp_xon, bf, bi);
    end

    // Single-generation run with a tie at the minimum: earlier index must win.
    fill_rand(600, 900);
    tab[0] = 300; tab[1] = 120; tab[2] = 120; tab[3] = 500;
    run_case("ties", 4, 0, 77, 4, 2, 4, 0, 4, 0, 120, 1);

    // Elitism across generations; a later equal fitness does not displace the holder.
    fill_rand(200, 200);
    for (int i = 0; i < 10; i++) begin tab[64 + i] = 150; tab[128 + i] = 120; tab[192 + i] = 95; end
    tab[5] = 100; tab[128 + 7] = 90; tab[192 + 3] = 90;
    run_case("elite", 10, 3, 128, 10, -1, 10, 5, 40, 3, 90, 7);

    for (int r = 0; r < 4; r++) begin
      ps = int'($urandom_range(1, 20)); ng = int'($urandom_range(0, 3));
      xf = int'($urandom_range(0, 255)); bt = int'($urandom_range(1, ps + 2));
      pe = clamp_pop(ps);
      fill_rand(0, 1023);
      model_best(pe, ng, bf, bi);
      run_case($sformatf("rand%0d", r), ps, ng, xf, bt, -1, (bt < pe) ? bt : pe,
               (ng > 0) ? (pe * xf) / 256 : 0, pe * (ng + 1), ng, bf, bi);
    end

    // Stray handshakes while idle must not start anything.
    clear_mon();
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    stray = 0;
    repeat (3) @(posedge clk);
    #1;
    check("stray.done", n_done, 0);
    check("stray.xo_start", n_xo, 0);
    check("stray.mut_start", n_mut, 0);
    check("stray.eval_req", eval_req, 0);

    // Reset pulse in the middle of the population stream.
    clear_mon();
    pop_eff_m = 20;
    in_valid = 1; Pop_size = 20; Num_generations = 1; crossoverFraction = 100;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("rst_mid.pop_wr_en", pop_wr_en, 0);
    check("rst_mid.pop_wr_addr", pop_wr_addr, 0);
    check("rst_mid.gen_cnt", gen_cnt, 0);
    check("rst_mid.xo_count", xo_count, 0);
    check("rst_mid.done", done, 0);
    in_valid = 0;
    #1;
    rst_n = 1;
    repeat (100) @(posedge clk);
    #1;
    check("rst_mid.no_done", n_done, 0);
    check("rst_mid.no_eval", n_eval, 0);
    check("rst_mid.eval_req", eval_req, 0);

    // Crossover never completes: watchdog abort, or indefinite wait without it.
    fixed_lat = 0;
    clear_mon();
    pop_eff_m = 2;
    fill_rand(100, 300);
    model_best(2, 0, bf, bi);
    xo_hold = 1;
    drive_cfg(2, 1, 128, 2);
    t = 0;
    while (n_xo == 0 && t < 500) begin @(posedge clk); t++; end
    check("wdog.xo_seen", n_xo, 1);
    t = 0;
    while (n_done == 0 && t < WD + 100) begin @(posedge clk); t++; end
    #1;
`ifdef WATCHDOG_EN
    check("wdog.done", n_done, 1);
    check("wdog.latency", done_cyc - xo_cyc, WD);
    check("wdog.err", cap_err, 1);
    check("wdog.min_fit", cap_fit, bf);
    check("wdog.best_idx", cap_idx, bi);
`else
    check("wdog.no_done", n_done, 0);
    check("wdog.err_low", err, 0);
`endif
    rst_n = 0;
    xo_hold = 0;
    #2;
    clear_mon();
    rst_n = 1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/ev3a_gen_ctrl.md
Name: ev3a_gen_ctrl

Overview:
- Generation sequencer for the EV3a evolutionary lattice-energy datapath.
- Captures run configuration and the streamed population write addresses during in_valid.
- Per generation, runs three phases over the population memory through request/acknowledge handshakes: fitness evaluation, crossover, mutation.
- Tracks the global best individual (elitist, persists across generations) and signals completion with a one-cycle done.

Parameters:
- INT8_LENGTH, 8, width of Num_generations, Pop_size, crossoverFraction and the generation counter
- IND_FIT_LENGTH, 10, fitness width
- MAX_POP, 64, population memory depth; Pop_size above this is clamped
- ADDR_W, 6, population address width (log2 MAX_POP)
- WDOG_CYCLES, 1023, watchdog limit (used only with WATCHDOG_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  configuration/population stream valid
- Num_generations  in  INT8_LENGTH  generation count, sampled on first in_valid cycle
- Pop_size  in  INT8_LENGTH  population size, sampled on first in_valid cycle
- crossoverFraction  in  INT8_LENGTH  crossover fraction in Q0.8, sampled on first in_valid cycle
- pop_wr_en  out  1  population memory write strobe
- pop_wr_addr  out  ADDR_W  population memory write address
- eval_req  out  1  fitness request, held until acknowledged
- eval_idx  out  ADDR_W  individual under evaluation
- eval_ack  in  1  fitness result valid
- fit_in  in  IND_FIT_LENGTH  fitness of eval_idx
- xo_start  out  1  one-cycle crossover start pulse
- xo_count  out  INT8_LENGTH  number of offspring to produce
- xo_done  in  1  crossover phase complete
- mut_start  out  1  one-cycle mutation start pulse
- mut_done  in  1  mutation phase complete
- gen_cnt  out  INT8_LENGTH  completed generations
- Min_fit_out  out  IND_FIT_LENGTH  best fitness; valid only while done=1
- Best_idx  out  ADDR_W  index of best individual; valid only while done=1
- done  out  1  run complete, one-cycle pulse
- err  out  1  watchdog abort flag, asserted together with done

Behaviour:
- Reset: all outputs 0; state IDLE; best_fit = all ones.
- Min_fit_out, Best_idx and err read 0 whenever done=0.
- States: IDLE, LOAD, EVAL, XOVER, MUTATE, DONE.
- IDLE:
  - On in_valid=1, latch configuration: pop = clamp(Pop_size, 1, MAX_POP); best_fit = all ones; gen_cnt = 0.
  - Drive pop_wr_en=1 with pop_wr_addr=0 in the same cycle; go to LOAD.
- LOAD:
  - Each in_valid cycle increments pop_wr_addr.
  - pop_wr_en is 0 once pop writes have been issued; surplus beats are ignored.
  - On in_valid=0, go to EVAL with eval_idx=0. A short stream still evaluates pop entries.
- in_valid outside IDLE/LOAD is ignored.
- EVAL:
  - eval_req asserts the cycle after entry and stays high until eval_ack.
  - On eval_ack: if fit_in < best_fit (strictly less), update best_fit and best_idx. Ties keep the earlier individual.
  - After the ack, eval_idx increments and eval_req drops for one cycle before the next request.
  - After index pop-1 is acknowledged: go to DONE if gen_cnt == Num_generations, otherwise go to XOVER.
  - Num_generations=0 therefore evaluates the initial population once and finishes.
- XOVER:
  - xo_start pulses on the entry cycle, with xo_count = (pop*crossoverFraction)>>8 using a 16-bit product.
  - Wait for xo_done, then go to MUTATE.
  - xo_done arriving in the same cycle as xo_start is accepted.
- MUTATE:
  - mut_start pulses on the entry cycle; wait for mut_done.
  - On mut_done: gen_cnt++, eval_idx=0, go to EVAL.
  - gen_cnt saturates at 255.
- DONE:
  - done=1 for exactly one cycle, with Min_fit_out=best_fit and Best_idx=best_idx.
  - Then return to IDLE; gen_cnt holds until the next run starts.
- Stray acknowledges: eval_ack, xo_done or mut_done received in a state that is not waiting on it is ignored.
- Reset mid-run: returns to IDLE immediately; no done is generated.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined:
  - A cycle counter clears on each state entry and counts while waiting for eval_ack, xo_done or mut_done.
  - Reaching WDOG_CYCLES forces DONE with err=1; Min_fit_out/Best_idx carry the best found so far.
- Undefined: no counter; err is tied to 0; the block waits indefinitely.

Test Plan:
- Reset asserted mid-LOAD (rst_n low 2 ns) -> all outputs 0 within the reset, state returns to IDLE, and no done follows.
- Pop_size=40, 40 in_valid beats -> pop_wr_addr runs 0..39 with pop_wr_en high for all 40 cycles; 42 beats -> pop_wr_en low on beats 41-42.
- Num_generations=0, Pop_size=4, fitness {300,120,120,500} with ack latency 2 -> exactly 4 requests, then done pulse with Min_fit_out=120, Best_idx=1; xo_start never pulses.
- Num_generations=2, Pop_size=40, crossoverFraction=204 -> xo_count=31, xo_start/mut_start each pulse twice, 120 evaluations, and done arrives with gen_cnt=2.
- Generation-2 fitness 90 at index 7 after generation-0 best of 100 -> Min_fit_out=90, Best_idx=7; a later 90 at index 3 does not replace it.
- WATCHDOG_EN defined, xo_done withheld -> done=1 and err=1 exactly WDOG_CYCLES cycles after xo_start; undefined -> done stays 0.
